// File: rtl/pl_ctrl_pkg.sv
// Shared encodings and constants for the pipeline hazard controller.
package pl_ctrl_pkg;

    localparam int unsigned STATE_W     = 2;
    localparam int unsigned FLUSH_CNT_W = 3;
    localparam int unsigned PC_W        = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MC_WAIT = 2'd2,
        ST_HALT    = 2'd3
    } pl_state_e;

    localparam logic [PC_W-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [PC_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pl_perf_counters.sv
// Saturating flush/stall event counters for the hazard controller.
module pl_perf_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_inc,
    input  logic             stall_inc,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Define PL_CTRL_PERF_EN to build the flush/stall performance counters.
module pipeline_hazard_ctrl
    import pl_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MC_TIMEOUT   = 64,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             B_type_branch_failed,
    input  logic             jalr_failed,
    input  logic [PC_W-1:0]  pc_branch_filled,
    input  logic             load_use_hazard,
    input  logic             mc_start,
    input  logic             mc_done,
    input  logic             halt_req,
    output logic             PL_stall,
    output logic             PL_flush,
    output logic [PC_W-1:0]  pc_rollback,
    output logic             mc_kill,
    output logic             halted,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam bit          TIMEOUT_EN = (MC_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0]      WAIT_LAST  = WAIT_W'(MC_TIMEOUT - 1);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    pl_state_e              state, next_state;
    logic [FLUSH_CNT_W-1:0] flush_left, flush_left_d;
    logic [WAIT_W-1:0]      wait_cnt, wait_cnt_d;
    logic [PC_W-1:0]        pc_d;
    logic                   kill_d;
    logic                   stall_c;
    logic                   fail;
    logic                   mc_timeout;

    assign fail       = B_type_branch_failed | jalr_failed;
    assign mc_timeout = TIMEOUT_EN && (wait_cnt == WAIT_LAST);
    assign PL_stall   = stall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            flush_left  <= '0;
            wait_cnt    <= '0;
            pc_rollback <= RESET_PC;
            mc_kill     <= 1'b0;
            PL_flush    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= next_state;
            flush_left  <= flush_left_d;
            wait_cnt    <= wait_cnt_d;
            pc_rollback <= pc_d;
            mc_kill     <= kill_d;
            PL_flush    <= (next_state == ST_FLUSH);
            halted      <= (next_state == ST_HALT);
        end
    end

    // Next state; priority fail > mc_start > halt_req > load_use_hazard.
    always_comb begin
        next_state   = state;
        flush_left_d = flush_left;
        wait_cnt_d   = wait_cnt;
        pc_d         = pc_rollback;
        kill_d       = 1'b0;
        stall_c      = 1'b0;
        unique case (state)
            ST_RUN: begin
                stall_c = load_use_hazard & ~fail;
                if (fail) begin
                    next_state   = ST_FLUSH;
                    pc_d         = pc_branch_filled;
                    flush_left_d = FLUSH_LOAD;
                    kill_d       = mc_start;
                end else if (mc_start) begin
                    next_state = ST_MC_WAIT;
                    wait_cnt_d = '0;
                end else if (halt_req) begin
                    next_state = ST_HALT;
                end
            end
            ST_FLUSH: begin
                if (fail) begin
                    pc_d         = pc_branch_filled;
                    flush_left_d = FLUSH_LOAD;
                end else if (flush_left == '0) begin
                    next_state = ST_RUN;
                end else begin
                    flush_left_d = flush_left - FLUSH_CNT_W'(1);
                end
            end
            ST_MC_WAIT: begin
                stall_c = ~mc_done & ~fail;
                if (fail) begin
                    next_state   = ST_FLUSH;
                    pc_d         = pc_branch_filled;
                    flush_left_d = FLUSH_LOAD;
                    kill_d       = ~mc_done;
                end else if (mc_done) begin
                    next_state = ST_RUN;
                end else if (mc_timeout) begin
                    next_state = ST_RUN;
                    kill_d     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + WAIT_W'(1);
                end
            end
            ST_HALT: begin
                stall_c = 1'b1;
                if (!halt_req) next_state = ST_RUN;
            end
            default: next_state = ST_RUN;
        endcase
    end

`ifdef PL_CTRL_PERF_EN
    logic flush_entry;
    assign flush_entry = (next_state == ST_FLUSH) && ((state != ST_FLUSH) || fail);

    pl_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_inc (flush_entry),
        .stall_inc (stall_c),
        .flush_cnt (flush_cnt),
        .stall_cnt (stall_cnt)
    );
`else
    assign flush_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
